serial_addsub: RTL and testbench
================================

# serial_addsub

Parametrised, multi-cycle add/subtract unit that processes a WIDTH-bit operand pair DIGIT bits per clock through a carry-registered ripple slice, with valid/ready handshakes on both sides and a full flag set (carry, overflow, zero, negative). It succeeds the fixed 8-bit combinational ripple adder. It gives the ALU a selectable add/sub mode and a width/area-versus-latency trade-off, and sits between the operand register file and the ALU result mux.

## Interface
- WIDTH, 16, operand/result width in bits; must be a multiple of DIGIT, ≥ 2
- DIGIT, 4, bits processed per cycle; 1 ≤ DIGIT ≤ WIDTH
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, synchronous, active-low
- in_valid  in  1  operand pair valid
- in_ready  out  1  unit can accept operands
- x  in  WIDTH  operand A
- y  in  WIDTH  operand B
- mode  in  1  1 = addition (x+y), 0 = subtraction (x−y)
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- sum  out  WIDTH  result
- cout  out  1  carry out; for subtraction 1 = no borrow
- ovf  out  1  signed (two's-complement) overflow
- zero  out  1  sum == 0
- neg  out  1  sum[WIDTH-1]

## Operation
- N = WIDTH/DIGIT digit steps per operation.
- States are IDLE, RUN and DONE. Reset (rst_n low at an edge) forces IDLE.
  - Reset values: in_ready=1, out_valid=0, sum=0, cout=0, ovf=0, zero=0, neg=0.
- IDLE: in_ready=1.
  - On in_valid & in_ready, latch x. Latch y, or ~y when mode=0.
  - Set the carry register to ~mode (the +1 for two's complement).
  - Clear the digit counter and go to RUN.
- RUN: in_ready=0, out_valid=0.
  - Each cycle, add digit k of the latched A and B with the carry register.
  - Write the DIGIT-bit result into sum[k·DIGIT +: DIGIT] and register the carry out.
  - After digit N−1 completes, go to DONE.
- DONE: out_valid=1.
  - sum and flags are held stable until out_valid & out_ready, then go to IDLE.
- Flags are computed when the last digit completes:
  - cout is the final carry.
  - ovf is the carry into the MSB XOR the carry out of the MSB.
  - zero and neg are computed from the full sum.
- sum/flags hold their last values in IDLE; only out_valid qualifies them. Cleared only by reset.
- in_valid/x/y/mode are ignored outside IDLE. Operands are not re-sampled during RUN.
- Arithmetic is modulo 2^WIDTH; no saturation.

## Timing
- Accept edge = rising edge with in_valid & in_ready high in IDLE.
- RUN occupies the N cycles after the accept edge.
- out_valid rises after the N-th edge following the accept edge: latency N cycles, accept to out_valid.
- in_ready falls on the accept edge and returns high the cycle after the output handshake edge.
- Throughput: one operation per N+2 cycles with out_ready held high.
- out_ready held low keeps DONE indefinitely, with sum/flags unchanged.
- No combinational path from in_valid/out_ready to any output.
- Reset asserted in RUN or DONE takes effect at the next edge:
  - The operation is discarded.
  - The state returns to IDLE.
  - All outputs take their reset values, with no out_valid pulse.
- DIGIT=WIDTH gives N=1: a single-cycle RUN, with the same handshake.

## Structure
- The package alu_pkg holds:
  - the state enum (IDLE/RUN/DONE);
  - the mode encoding constants MODE_SUB=0 and MODE_ADD=1;
  - a function computing the counter width $clog2(N) (minimum 1).
- Sub-module digit_rca is a DIGIT-wide combinational ripple-carry slice.
  - Ports: a[DIGIT-1:0], b[DIGIT-1:0], cin → s, cout, and c_msb_in (carry into its top bit, for ovf).
  - It is built from per-bit full-adder cells.
- The top-level module holds:
  - the FSM;
  - the digit counter;
  - the operand shift or indexing;
  - the carry register;
  - the flag logic.

## Test plan
- Add with signed overflow: x=0x7FFF, y=0x0001, mode=1.
  - Result: sum=0x8000, cout=0, ovf=1, neg=1, zero=0.
  - out_valid rises exactly 4 cycles after accept.
- Equal-operand subtract: x=0x1234, y=0x1234, mode=0.
  - Result: sum=0x0000, cout=1, zero=1, ovf=0.
- Borrow on subtract: x=0x0000, y=0x0001, mode=0.
  - Result: sum=0xFFFF, cout=0, neg=1, ovf=0.
- Unsigned wrap on add: x=0xFFFF, y=0x0001, mode=1.
  - Result: sum=0x0000, cout=1, zero=1.
- Backpressure, with a second in_valid presented during RUN:
  - The second operand is not accepted.
  - With out_ready low for 5 cycles in DONE, sum/flags stay stable and in_ready stays 0.
  - The handshake then completes, and in_ready is 1 on the next cycle.
- Reset mid-RUN: drive rst_n=0 at cycle 2 of RUN.
  - Next cycle: IDLE, all outputs zero, out_valid never asserted.
  - Repeat the first scenario at WIDTH=8, DIGIT=8 (N=1): sum=0x80 one cycle after accept.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and constants for the serial add/subtract unit.
// Holds the FSM state encoding, mode encoding and the digit-counter sizing helper.
package alu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic MODE_SUB = 1'b0;
  localparam logic MODE_ADD = 1'b1;

  // A single-digit operation still needs a 1-bit counter so the compare stays legal.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/digit_rca.sv
// DIGIT-wide combinational ripple-carry slice built from per-bit full-adder cells.
// Exposes the carry into its top bit so the parent can derive signed overflow.
module digit_rca #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] s,
  output logic             cout,
  output logic             c_msb_in
);

  logic [DIGIT:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    logic p;
    assign p        = a[i] ^ b[i];
    assign s[i]     = p ^ c[i];
    assign c[i + 1] = (a[i] & b[i]) | (c[i] & p);
  end

  assign cout     = c[DIGIT];
  assign c_msb_in = c[DIGIT-1];

endmodule

// File: rtl/serial_addsub.sv
// Multi-cycle add/subtract unit: DIGIT bits per clock through a carry-registered ripple slice.
// state   | meaning
// IDLE    | in_ready high, waiting for an operand pair
// RUN     | one digit per cycle, carry held in a register between digits
// DONE    | out_valid high, result and flags held until consumed
module serial_addsub
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             neg
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = cnt_width(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_e           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             carry;

  logic [DIGIT-1:0] d_sum;
  logic             d_cout;
  logic             d_cmsb;
  logic [WIDTH-1:0] sum_next;

  // Operands are shifted right each step, so the slice always sees the low digit.
  digit_rca #(.DIGIT(DIGIT)) u_rca (
    .a        (a_q[DIGIT-1:0]),
    .b        (b_q[DIGIT-1:0]),
    .cin      (carry),
    .s        (d_sum),
    .cout     (d_cout),
    .c_msb_in (d_cmsb)
  );

  always_comb begin
    sum_next = sum;
    sum_next[int'(cnt) * DIGIT +: DIGIT] = d_sum;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      carry <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
      zero  <= 1'b0;
      neg   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            a_q   <= x;
            b_q   <= (mode == MODE_ADD) ? y : ~y;
            carry <= ~mode;
            cnt   <= '0;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          sum   <= sum_next;
          carry <= d_cout;
          a_q   <= a_q >> DIGIT;
          b_q   <= b_q >> DIGIT;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) begin
            cout  <= d_cout;
            ovf   <= d_cmsb ^ d_cout;
            zero  <= (sum_next == '0);
            neg   <= sum_next[WIDTH-1];
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);

endmodule

// File: tb/tb_serial_addsub.sv
// Directed bench for serial_addsub: a 16/4 instance and an 8/8 single-step instance.
// Expected values are hand-computed; inputs change and outputs are sampled on the falling edge.
module tb_serial_addsub;

  logic clk = 1'b0;
  logic rst_n;

  logic        a_in_valid, a_in_ready, a_mode, a_out_valid, a_out_ready;
  logic [15:0] a_x, a_y, a_sum;
  logic        a_cout, a_ovf, a_zero, a_neg;

  logic        b_in_valid, b_in_ready, b_mode, b_out_valid, b_out_ready;
  logic [7:0]  b_x, b_y, b_sum;
  logic        b_cout, b_ovf, b_zero, b_neg;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  serial_addsub #(.WIDTH(16), .DIGIT(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .x(a_x), .y(a_y), .mode(a_mode), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .sum(a_sum), .cout(a_cout), .ovf(a_ovf), .zero(a_zero), .neg(a_neg)
  );

  serial_addsub #(.WIDTH(8), .DIGIT(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .x(b_x), .y(b_y), .mode(b_mode), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .sum(b_sum), .cout(b_cout), .ovf(b_ovf), .zero(b_zero), .neg(b_neg)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // flags packed as {cout, ovf, zero, neg}
  task automatic op_a(input string tag, input logic [15:0] xv, input logic [15:0] yv,
                      input logic md, input logic [15:0] exp_sum, input logic [3:0] exp_flags);
    int n;
    a_x = xv; a_y = yv; a_mode = md; a_in_valid = 1'b1;
    @(negedge clk);
    a_in_valid = 1'b0; a_x = 16'hDEAD; a_y = 16'hBEEF; a_mode = ~md;
    check({tag, "_ready_low"}, 32'(a_in_ready), 32'd0);
    n = 0;
    while (!a_out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_latency"}, 32'(n), 32'd4);
    check({tag, "_sum"}, 32'(a_sum), 32'(exp_sum));
    check({tag, "_flags"}, 32'({a_cout, a_ovf, a_zero, a_neg}), 32'(exp_flags));
    a_out_ready = 1'b1;
    @(negedge clk);
    a_out_ready = 1'b0;
    check({tag, "_ready_back"}, 32'({a_in_ready, a_out_valid}), 32'b10);
    check({tag, "_sum_hold"}, 32'(a_sum), 32'(exp_sum));
  endtask

  task automatic op_b(input string tag, input logic [7:0] xv, input logic [7:0] yv,
                      input logic md, input logic [7:0] exp_sum, input logic [3:0] exp_flags);
    int n;
    b_x = xv; b_y = yv; b_mode = md; b_in_valid = 1'b1;
    @(negedge clk);
    b_in_valid = 1'b0;
    check({tag, "_ready_low"}, 32'(b_in_ready), 32'd0);
    n = 0;
    while (!b_out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_latency"}, 32'(n), 32'd1);
    check({tag, "_sum"}, 32'(b_sum), 32'(exp_sum));
    check({tag, "_flags"}, 32'({b_cout, b_ovf, b_zero, b_neg}), 32'(exp_flags));
    b_out_ready = 1'b1;
    @(negedge clk);
    b_out_ready = 1'b0;
    check({tag, "_ready_back"}, 32'({b_in_ready, b_out_valid}), 32'b10);
  endtask

  initial begin
    int n;
    logic [15:0] held;
    rst_n = 1'b0;
    a_in_valid = 1'b0; a_out_ready = 1'b0; a_x = '0; a_y = '0; a_mode = 1'b1;
    b_in_valid = 1'b0; b_out_ready = 1'b0; b_x = '0; b_y = '0; b_mode = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_a_hs", 32'({a_in_ready, a_out_valid}), 32'b10);
    check("rst_a_out", 32'({a_sum, a_cout, a_ovf, a_zero, a_neg}), 32'd0);
    check("rst_b_hs", 32'({b_in_ready, b_out_valid}), 32'b10);
    rst_n = 1'b1;
    @(negedge clk);

    op_a("add_ovf",   16'h7FFF, 16'h0001, 1'b1, 16'h8000, 4'b0101);
    op_a("sub_equal", 16'h1234, 16'h1234, 1'b0, 16'h0000, 4'b1010);
    op_a("sub_borrow",16'h0000, 16'h0001, 1'b0, 16'hFFFF, 4'b0001);
    op_a("add_wrap",  16'hFFFF, 16'h0001, 1'b1, 16'h0000, 4'b1010);
    op_a("add_plain", 16'h5A5A, 16'h1111, 1'b1, 16'h6B6B, 4'b0000);
    op_a("sub_ovf",   16'h8000, 16'h0001, 1'b0, 16'h7FFF, 4'b1100);

    // Backpressure: a second operand offered during RUN must be ignored.
    a_x = 16'h0100; a_y = 16'h0023; a_mode = 1'b1; a_in_valid = 1'b1;
    @(negedge clk);
    a_x = 16'hFFFF; a_y = 16'hFFFF; a_mode = 1'b0;
    repeat (2) @(negedge clk);
    a_in_valid = 1'b0;
    n = 0;
    while (!a_out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("bp_sum", 32'(a_sum), 32'h0123);
    check("bp_flags", 32'({a_cout, a_ovf, a_zero, a_neg}), 32'b0000);
    held = a_sum;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_hold_hs", 32'({a_out_valid, a_in_ready}), 32'b10);
      check("bp_hold_sum", 32'(a_sum), 32'(held));
    end
    a_out_ready = 1'b1;
    @(negedge clk);
    a_out_ready = 1'b0;
    check("bp_release", 32'({a_in_ready, a_out_valid}), 32'b10);

    // Reset during the second RUN cycle discards the operation.
    a_x = 16'h7FFF; a_y = 16'h0001; a_mode = 1'b1; a_in_valid = 1'b1;
    @(negedge clk);
    a_in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_run_hs", 32'({a_in_ready, a_out_valid}), 32'b10);
    check("rst_run_out", 32'({a_sum, a_cout, a_ovf, a_zero, a_neg}), 32'd0);
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (a_out_valid) n++;
    end
    check("rst_run_no_valid", 32'(n), 32'd0);

    op_b("b_add_ovf", 8'h7F, 8'h01, 1'b1, 8'h80, 4'b0101);
    op_b("b_sub",     8'h10, 8'h20, 1'b0, 8'hF0, 4'b0001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
